nist_pattern_gen: RTL and testbench
===================================

NIST_PATTERN_GEN -- requirements
Module: nist_pattern_gen

Interface
REQ-001 SHALL have parameter SEQ_LEN_W, default 16, meaning width of the sequence-length and bit-index counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a sequence.
REQ-005 SHALL have port abort, input, 1, to terminate a running sequence.
REQ-006 SHALL have port mode, input, 3, pattern select, sampled with start.
REQ-007 SHALL have port seq_len, input, SEQ_LEN_W, number of bits to emit, sampled with start.
REQ-008 SHALL have port seed, input, 16, LFSR seed, sampled with start.
REQ-009 SHALL have port bit_en, input, 1, consumer accept; a bit transfers when rnd_valid and bit_en.
REQ-010 SHALL have port rnd_out, output, 1, serial test bit feeding the NIST tester RND_in.
REQ-011 SHALL have port rnd_valid, output, 1, high while rnd_out holds a bit.
REQ-012 SHALL have port busy, output, 1, high in LOAD and RUN.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port err_in, input, 4, error1..error4 from the tester.
REQ-015 SHALL have port err_latched, output, 4, sticky error capture.
REQ-016 SHALL have port first_err_idx, output, SEQ_LEN_W, bit index at first error.

Function
REQ-017 SHALL implement FSM IDLE->LOAD->RUN->DONE->IDLE.
REQ-018 SHALL leave IDLE for LOAD on the first edge with start=1; start in any other state SHALL be ignored.
REQ-019 SHALL, in LOAD, register mode, seq_len, and seed, clear the bit counter, and go to RUN next edge (first bit valid two edges after start).
REQ-020 SHALL go from LOAD to DONE directly when seq_len=0, emitting no bits.
REQ-021 SHALL, in RUN, hold rnd_valid=1, and on each transfer advance the pattern and increment the bit counter.
REQ-022 SHALL keep rnd_out and the pattern state unchanged while bit_en=0.
REQ-023 SHALL go to DONE on the transfer of bit index seq_len-1.
REQ-024 SHALL assert done for exactly the single DONE cycle, then return to IDLE.
REQ-025 SHALL force IDLE on the next edge when abort=1 in LOAD or RUN, with no done pulse; abort SHALL take priority over a simultaneous last transfer.
REQ-026 SHALL produce patterns per mode: 0 all zeros; 1 all ones; 2 alternating starting 0; 3 LFSR; 4 biased, ~75% ones (OR of LFSR bits 0 and 1); 5 runs of 8 ones then 8 zeros; 6 and 7 all zeros.
REQ-027 SHALL make the LFSR a 16-bit Fibonacci right-shift register with rnd_out = bit0, feedback = b0^b2^b3^b5 into bit15, and a zero seed replaced by 16'h0001.
REQ-028 SHALL drive rnd_out=0 whenever rnd_valid=0.

Reset
REQ-029 SHALL, on rst_n low, asynchronously set state IDLE, LFSR 16'h0001, counter 0, and rnd_out, rnd_valid, busy, done, err_latched, and first_err_idx to 0.

Configuration
REQ-030 SHALL, with macro NIST_PATTERN_ERR_CAPTURE_EN defined, OR err_in into err_latched on each RUN cycle, and load first_err_idx with the counter on the first cycle err_latched goes from 0 to nonzero.
REQ-031 SHALL, with NIST_PATTERN_ERR_CAPTURE_EN defined, clear err_latched and first_err_idx in LOAD.
REQ-032 SHALL, without NIST_PATTERN_ERR_CAPTURE_EN, keep the ports, tie err_latched and first_err_idx to 0, and leave err_in unused.

Structure
REQ-033 SHALL put the mode codes, state encoding, LFSR tap constant, and nonzero default seed in package nist_pattern_pkg.
REQ-034 SHALL put the LFSR in sub-module nist_pattern_lfsr16, which has load, seed, step, and the 16-bit state out.

Verification
REQ-035 SHALL cover: mode 3, seed 16'hACE1, seq_len 16, bit_en=1 -> rnd_out LSB-first 1,0,0,0,0,1,1,1,0,0,1,1,0,1,0,1, then done once.
REQ-036 SHALL cover: mode 2, seq_len 5, bit_en toggling every cycle -> 0,1,0,1,0 on transfers only, done after the 5th transfer.
REQ-037 SHALL cover: seq_len 0 -> busy for 1 cycle, rnd_valid never high, done pulses 2 edges after start.
REQ-038 SHALL cover: mode 1, seq_len 100, abort at bit index 40 -> IDLE next edge, no done, and start during RUN ignored.
REQ-039 SHALL cover: NIST_PATTERN_ERR_CAPTURE_EN defined, mode 0, seq_len 64, err_in=4'b0010 pulsed at index 20 -> err_latched=4'b0010, first_err_idx=20, both cleared on the next start.
REQ-040 SHALL cover: rst_n asserted mid-RUN -> all outputs 0 immediately, and mode 3 with seed 0 emits the 16'h0001 sequence.

Source files
------------

// File: rtl/nist_pattern_pkg.sv
// nist_pattern_pkg
// Shared definitions for the NIST test-pattern generator: FSM state encoding,
// pattern mode codes, LFSR tap mask, the nonzero default seed, and small
// helper functions used by both the top level and the LFSR sub-module.
// Ports: none (package only).
package nist_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    MODE_ZEROS  = 3'd0,
    MODE_ONES   = 3'd1,
    MODE_ALT    = 3'd2,
    MODE_LFSR   = 3'd3,
    MODE_BIASED = 3'd4,
    MODE_RUNS   = 3'd5,
    MODE_RSVD6  = 3'd6,
    MODE_RSVD7  = 3'd7
  } mode_t;

  // Feedback taps b0, b2, b3, b5 of the right-shifting Fibonacci LFSR.
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'h0001;

  // An all-zero LFSR would lock up, so a zero seed is swapped for the default.
  function automatic logic [15:0] lfsr_fix_seed(input logic [15:0] seed);
    return (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  // Output bit for a given mode. idx_b0 and idx_b3 are bits 0 and 3 of the
  // bit index, which is all the counter-based patterns need.
  function automatic logic pattern_bit(input mode_t mode, input logic [15:0] lfsr,
                                       input logic idx_b0, input logic idx_b3);
    logic b;
    case (mode)
      MODE_ONES:   b = 1'b1;
      MODE_ALT:    b = idx_b0;
      MODE_LFSR:   b = lfsr[0];
      MODE_BIASED: b = lfsr[0] | lfsr[1];
      MODE_RUNS:   b = ~idx_b3;
      default:     b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nist_pattern_lfsr16.sv
// nist_pattern_lfsr16
// 16-bit Fibonacci right-shift LFSR. Output bit is state[0]; feedback is
// b0^b2^b3^b5 shifted into bit 15. A zero seed is replaced by 16'h0001.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (state -> 16'h0001)
//   load, seed  - load the (zero-corrected) seed; load wins over step
//   step        - advance one position
//   state       - current 16-bit register contents
module nist_pattern_lfsr16
  import nist_pattern_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = lfsr_fix_seed(seed);
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_DEFAULT_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/nist_pattern_gen.sv
// nist_pattern_gen
// Serial test-pattern source for a NIST randomness tester. A one-cycle start
// captures mode/seq_len/seed; the block then emits seq_len bits on rnd_out
// with a valid/accept handshake (rnd_valid/bit_en), pulses done, and returns
// to IDLE. abort terminates a sequence without a done pulse.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, abort        - begin / terminate a sequence
//   mode, seq_len, seed - sequence configuration, sampled with start
//   bit_en              - consumer accept; a bit moves on rnd_valid & bit_en
//   rnd_out, rnd_valid  - serial bit and its qualifier (rnd_out=0 when idle)
//   busy, done          - busy in LOAD/RUN, done one cycle at completion
//   err_in              - tester error flags error1..error4
//   err_latched         - sticky OR of err_in seen during RUN
//   first_err_idx       - bit index when err_latched first became nonzero
// Optional feature: define NIST_PATTERN_ERR_CAPTURE_EN to enable error capture;
// otherwise err_latched and first_err_idx read as 0 and err_in is ignored.
module nist_pattern_gen
  import nist_pattern_pkg::*;
#(
  parameter int SEQ_LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2:0]           mode,
  input  logic [SEQ_LEN_W-1:0] seq_len,
  input  logic [15:0]          seed,
  input  logic                 bit_en,
  output logic                 rnd_out,
  output logic                 rnd_valid,
  output logic                 busy,
  output logic                 done,
  input  logic [3:0]           err_in,
  output logic [3:0]           err_latched,
  output logic [SEQ_LEN_W-1:0] first_err_idx
);

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [SEQ_LEN_W-1:0] seq_len_q, seq_len_d;
  logic [15:0]          seed_q, seed_d;
  logic [SEQ_LEN_W-1:0] cnt_q, cnt_d;
  logic                 rnd_out_q, rnd_out_d;
  logic                 rnd_valid_q, rnd_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 lfsr_load;
  logic                 lfsr_step;
  logic [15:0]          lfsr_state;
  logic                 transfer;
  logic                 last_bit;
  logic [SEQ_LEN_W-1:0] cnt_inc;
  logic [15:0]          lfsr_after_step;

  nist_pattern_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed_q),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  assign transfer        = (state_q == ST_RUN) && rnd_valid_q && bit_en;
  assign last_bit        = (cnt_q == seq_len_q - SEQ_LEN_W'(1));
  assign cnt_inc         = cnt_q + SEQ_LEN_W'(1);
  assign lfsr_after_step = lfsr_next(lfsr_state);

  // Next-state logic. Outputs are registered, so rnd_out_d is the bit for the
  // index that will be presented after this edge, computed from the LFSR
  // value the sub-module is about to hold.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    seq_len_d   = seq_len_q;
    seed_d      = seed_q;
    cnt_d       = cnt_q;
    rnd_out_d   = rnd_out_q;
    rnd_valid_d = rnd_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rnd_out_d   = 1'b0;
        rnd_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (start) begin
          mode_d    = mode_t'(mode);
          seq_len_d = seq_len;
          seed_d    = seed;
          state_d   = ST_LOAD;
          busy_d    = 1'b1;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          lfsr_load = 1'b1;
          cnt_d     = '0;
          if (seq_len_q == '0) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_RUN;
            rnd_valid_d = 1'b1;
            rnd_out_d   = pattern_bit(mode_q, lfsr_fix_seed(seed_q), 1'b0, 1'b0);
          end
        end
      end

      ST_RUN: begin
        // abort beats a simultaneous final transfer.
        if (abort) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          rnd_valid_d = 1'b0;
          rnd_out_d   = 1'b0;
        end else if (transfer) begin
          lfsr_step = 1'b1;
          if (last_bit) begin
            state_d     = ST_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            rnd_valid_d = 1'b0;
            rnd_out_d   = 1'b0;
          end else begin
            cnt_d     = cnt_inc;
            rnd_out_d = pattern_bit(mode_q, lfsr_after_step, cnt_inc[0], cnt_inc[3]);
          end
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        rnd_valid_d = 1'b0;
        rnd_out_d   = 1'b0;
        busy_d      = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ZEROS;
      seq_len_q   <= '0;
      seed_q      <= LFSR_DEFAULT_SEED;
      cnt_q       <= '0;
      rnd_out_q   <= 1'b0;
      rnd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      seq_len_q   <= seq_len_d;
      seed_q      <= seed_d;
      cnt_q       <= cnt_d;
      rnd_out_q   <= rnd_out_d;
      rnd_valid_q <= rnd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rnd_out   = rnd_out_q;
  assign rnd_valid = rnd_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef NIST_PATTERN_ERR_CAPTURE_EN
  logic [3:0]           err_latched_q, err_latched_d;
  logic [SEQ_LEN_W-1:0] first_err_idx_q, first_err_idx_d;

  // Errors accumulate only while bits are being emitted; the index snapshot
  // is taken on the cycle the sticky flags first become nonzero.
  always_comb begin
    err_latched_d   = err_latched_q;
    first_err_idx_d = first_err_idx_q;
    if (state_q == ST_LOAD) begin
      err_latched_d   = '0;
      first_err_idx_d = '0;
    end else if (state_q == ST_RUN) begin
      err_latched_d = err_latched_q | err_in;
      if ((err_latched_q == 4'b0000) && (err_in != 4'b0000)) begin
        first_err_idx_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_latched_q   <= '0;
      first_err_idx_q <= '0;
    end else begin
      err_latched_q   <= err_latched_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign err_latched   = err_latched_q;
  assign first_err_idx = first_err_idx_q;
`else
  logic unused_err_in;
  assign unused_err_in = ^err_in;
  assign err_latched   = '0;
  assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_nist_pattern_gen.sv
// tb_nist_pattern_gen
// Self-checking bench for nist_pattern_gen: directed scenarios plus randomized
// sequences, all compared against a bit-level reference model of the pattern
// rules. Honors NIST_PATTERN_ERR_CAPTURE_EN for the error-capture outputs.
`timescale 1ns/1ps
module tb_nist_pattern_gen;

  localparam int SEQ_LEN_W = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 abort;
  logic [2:0]           mode;
  logic [SEQ_LEN_W-1:0] seq_len;
  logic [15:0]          seed;
  logic                 bit_en;
  logic                 rnd_out;
  logic                 rnd_valid;
  logic                 busy;
  logic                 done;
  logic [3:0]           err_in;
  logic [3:0]           err_latched;
  logic [SEQ_LEN_W-1:0] first_err_idx;

  int nVectors = 0;
  int nFails   = 0;
  bit expQ[$];

  nist_pattern_gen #(.SEQ_LEN_W(SEQ_LEN_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .mode          (mode),
    .seq_len       (seq_len),
    .seed          (seed),
    .bit_en        (bit_en),
    .rnd_out       (rnd_out),
    .rnd_valid     (rnd_valid),
    .busy          (busy),
    .done          (done),
    .err_in        (err_in),
    .err_latched   (err_latched),
    .first_err_idx (first_err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait somewhere never completes.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected bits straight from the pattern rules.
  task automatic modelFill(input int md, input int len, input logic [15:0] sd);
    logic [15:0] s;
    bit b;
    expQ.delete();
    s = (sd == 16'h0000) ? 16'h0001 : sd;
    for (int i = 0; i < len; i++) begin
      case (md)
        1:       b = 1'b1;
        2:       b = ((i % 2) == 1);
        3:       b = s[0];
        4:       b = s[0] | s[1];
        5:       b = (((i / 8) % 2) == 0);
        default: b = 1'b0;
      endcase
      expQ.push_back(b);
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end
  endtask

  // Runs one sequence against expQ. enPolicy: 0 always accept, 1 toggle,
  // 2 random. abortAt/glitchAt/errAt are bit indices or -1 for none.
  task automatic applyStimulus(input int md, input int len, input logic [15:0] sd,
                               input int enPolicy, input int abortAt, input int glitchAt,
                               input int errAt, input logic [3:0] errVal);
    int idx = 0;
    int cycles = 0;
    bit en;
    bit toggle = 1'b1;
    bit aborted;
    bit glitched = 1'b0;
    logic [3:0] errModel = 4'b0000;
    int firstModel = 0;

    @(negedge clk);
    mode = 3'(md); seq_len = SEQ_LEN_W'(len); seed = sd; start = 1'b1; bit_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_valid", 32'(rnd_valid), 32'd0);
    @(negedge clk);
    mode = 3'($urandom); seq_len = SEQ_LEN_W'($urandom); seed = 16'($urandom);

    if (len == 0) begin
      checkOutput("len0_done", 32'(done), 32'd1);
      checkOutput("len0_busy", 32'(busy), 32'd0);
      checkOutput("len0_valid", 32'(rnd_valid), 32'd0);
      @(negedge clk);
      checkOutput("len0_done_once", 32'(done), 32'd0);
      checkOutput("len0_valid_after", 32'(rnd_valid), 32'd0);
      return;
    end

    checkOutput("err_cleared", 32'(err_latched), 32'd0);
    checkOutput("idx_cleared", 32'(first_err_idx), 32'd0);

    forever begin
      checkOutput("valid", 32'(rnd_valid), 32'd1);
      checkOutput("rnd_out", 32'(rnd_out), 32'(expQ[idx]));
      checkOutput("run_done", 32'(done), 32'd0);
      case (enPolicy)
        0:       en = 1'b1;
        1:       begin en = toggle; toggle = ~toggle; end
        default: en = 1'($urandom_range(0, 1));
      endcase
      bit_en = en;
      abort  = (idx == abortAt);
      err_in = (idx == errAt) ? errVal : 4'b0000;
      if (err_in != 4'b0000) begin
        if (errModel == 4'b0000) firstModel = idx;
        errModel = errModel | err_in;
      end
      if ((idx == glitchAt) && !glitched) begin
        start = 1'b1; mode = 3'd0; seq_len = SEQ_LEN_W'(2); glitched = 1'b1;
      end
      @(posedge clk);
      aborted = abort;
      if (!aborted && en) idx++;
      @(negedge clk);
      abort = 1'b0; err_in = 4'b0000; start = 1'b0; bit_en = 1'b0;
      if (aborted) begin
        checkOutput("abort_valid", 32'(rnd_valid), 32'd0);
        checkOutput("abort_out", 32'(rnd_out), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("abort_no_done2", 32'(done), 32'd0);
        break;
      end
      if (idx == len) begin
        checkOutput("end_done", 32'(done), 32'd1);
        checkOutput("end_valid", 32'(rnd_valid), 32'd0);
        checkOutput("end_out", 32'(rnd_out), 32'd0);
        checkOutput("end_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("done_once", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        break;
      end
      cycles++;
      if (cycles > len * 20 + 100) begin
        checkOutput("timeout", 32'd0, 32'd1);
        break;
      end
    end

`ifdef NIST_PATTERN_ERR_CAPTURE_EN
    checkOutput("err_latched", 32'(err_latched), 32'(errModel));
    checkOutput("first_err_idx", 32'(first_err_idx), 32'(firstModel));
`else
    checkOutput("err_latched_off", 32'(err_latched), 32'd0);
    checkOutput("first_err_idx_off", 32'(first_err_idx), 32'd0);
`endif
  endtask

  // Asynchronous reset in the middle of a running LFSR sequence.
  task automatic resetMidRun();
    @(negedge clk);
    mode = 3'd3; seq_len = SEQ_LEN_W'(50); seed = 16'hBEEF; start = 1'b1; bit_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    err_in = 4'b1000;
    @(negedge clk);
    err_in = 4'b0000;
    checkOutput("pre_reset_valid", 32'(rnd_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outs",
                32'({rnd_out, rnd_valid, busy, done, err_latched, first_err_idx}), 32'd0);
    @(negedge clk);
    bit_en = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    static int ref035[16] = '{1,0,0,0,0,1,1,1,0,0,1,1,0,1,0,1};
    int md, len, pol, abortAt, errAt, glitchAt;
    logic [15:0] sd;
    logic [3:0] ev;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; seq_len = '0;
    seed = '0; bit_en = 1'b0; err_in = '0;
    #12;
    checkOutput("reset_outs",
                32'({rnd_out, rnd_valid, busy, done, err_latched, first_err_idx}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset released");

    // LFSR seed ACE1, bits taken from the documented sequence.
    expQ.delete();
    foreach (ref035[i]) expQ.push_back(ref035[i] != 0);
    applyStimulus(3, 16, 16'hACE1, 0, -1, -1, -1, 4'b0000);

    modelFill(2, 5, 16'h0);
    applyStimulus(2, 5, 16'h0, 1, -1, -1, -1, 4'b0000);

    expQ.delete();
    applyStimulus(0, 0, 16'h1234, 0, -1, -1, -1, 4'b0000);

    modelFill(1, 100, 16'h0);
    applyStimulus(1, 100, 16'h0, 0, 40, 10, -1, 4'b0000);

    modelFill(0, 64, 16'h0);
    applyStimulus(0, 64, 16'h0, 0, -1, -1, 20, 4'b0010);

    // Abort coinciding with the final transfer must win.
    modelFill(2, 8, 16'h0);
    applyStimulus(2, 8, 16'h0, 0, 7, -1, -1, 4'b0000);

    modelFill(5, 40, 16'h0);
    applyStimulus(5, 40, 16'h0, 2, -1, -1, -1, 4'b0000);

    modelFill(4, 32, 16'h5A5A);
    applyStimulus(4, 32, 16'h5A5A, 2, -1, -1, -1, 4'b0000);

    resetMidRun();

    modelFill(3, 20, 16'h0000);
    applyStimulus(3, 20, 16'h0000, 0, -1, -1, -1, 4'b0000);

    for (int n = 0; n < 30; n++) begin
      md  = int'($urandom_range(0, 7));
      len = int'($urandom_range(0, 40));
      sd  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      pol = int'($urandom_range(0, 2));
      abortAt  = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      errAt    = (len > 0 && $urandom_range(0, 1) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      glitchAt = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      ev = 4'($urandom_range(1, 15));
      modelFill(md, len, sd);
      applyStimulus(md, len, sd, pol, abortAt, glitchAt, errAt, ev);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
    $finish;
  end

endmodule
